// File: rtl/as65_pio.sv
// Parallel I/O block: per-port DDR/PORT/IFR/IER registers on a CPU bus,
// pad synchronizers with armed edge detection and an active-low interrupt.
module as65_pio #(
    parameter int unsigned WIDTH        = 6,
    parameter int unsigned PORTS        = 1,
    parameter logic [15:0] BASE         = 16'h0000,
    parameter logic [7:0]  DDR_RST      = 8'h00,
    parameter logic [7:0]  PORT_RST     = 8'h00,
    parameter logic [7:0]  ALT_DDR_RST  = 8'h2F,
    parameter logic [7:0]  ALT_PORT_RST = 8'h27,
    parameter bit          EDGE         = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   preset_i,
    input  logic [15:0]            addr_i,
    input  logic [7:0]             wdata_i,
    input  logic                   we_i,
    output logic [7:0]             rdata_o,
    output logic                   hit_o,
    input  logic [PORTS*WIDTH-1:0] pio_in_i,
    output logic [PORTS*WIDTH-1:0] pio_out_o,
    output logic [PORTS*WIDTH-1:0] pio_oe_o,
    output logic                   irq_n_o
);

    localparam int unsigned NB     = PORTS * WIDTH;
    // 18-bit address math so a window running past 16'hFFFF cannot wrap to low addresses
    localparam logic [17:0] BASE_X = 18'(BASE);
    localparam logic [17:0] END_X  = BASE_X + 18'(4 * PORTS);

    logic [NB-1:0]    ddr_q, ddr_d, port_q, port_d, ifr_q, ifr_d, ier_q, ier_d;
    logic [NB-1:0]    s1_q, s2_q, s3_q, clr_c, edge_c;
    logic [1:0]       arm_q;
    logic [17:0]      addr_x, off_c;
    logic [WIDTH-1:0] wval_c, rst_ddr_c, rst_port_c, rd_c;

    assign addr_x     = {2'b00, addr_i};
    assign hit_o      = (addr_x >= BASE_X) && (addr_x < END_X);
    assign off_c      = addr_x - BASE_X;
    assign wval_c     = WIDTH'(wdata_i);
    assign rst_ddr_c  = preset_i ? WIDTH'(ALT_DDR_RST)  : WIDTH'(DDR_RST);
    assign rst_port_c = preset_i ? WIDTH'(ALT_PORT_RST) : WIDTH'(PORT_RST);

    // Register decode: write next-state, W1C mask and read mux
    always_comb begin
        ddr_d  = ddr_q;
        port_d = port_q;
        ier_d  = ier_q;
        clr_c  = '0;
        rd_c   = '0;
        for (int p = 0; p < int'(PORTS); p++) begin
            if (hit_o && (off_c[17:2] == 16'(p))) begin
                case (off_c[1:0])
                    2'd0: begin
                        rd_c = ddr_q[p*WIDTH +: WIDTH];
                        if (we_i) ddr_d[p*WIDTH +: WIDTH] = wval_c;
                    end
                    2'd1: begin
                        rd_c = (ddr_q[p*WIDTH +: WIDTH] & port_q[p*WIDTH +: WIDTH])
                             | (~ddr_q[p*WIDTH +: WIDTH] & s2_q[p*WIDTH +: WIDTH]);
                        if (we_i) port_d[p*WIDTH +: WIDTH] = wval_c;
                    end
                    2'd2: begin
                        rd_c = ifr_q[p*WIDTH +: WIDTH];
                        if (we_i) clr_c[p*WIDTH +: WIDTH] = wval_c;
                    end
                    default: begin
                        rd_c = ier_q[p*WIDTH +: WIDTH];
                        if (we_i) ier_d[p*WIDTH +: WIDTH] = wval_c;
                    end
                endcase
            end
        end
    end

    // Edge detect on input bits only, gated until the synchronizers have settled; set beats clear
    assign edge_c  = (EDGE ? (s2_q & ~s3_q) : (s3_q & ~s2_q)) & ~ddr_q & {NB{arm_q == 2'd3}};
    assign ifr_d   = (ifr_q & ~clr_c) | edge_c;
    assign rdata_o = 8'(rd_c);
    assign irq_n_o = ~|(ifr_q & ier_q);

    assign pio_out_o = port_q;
    assign pio_oe_o  = ddr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ddr_q  <= {PORTS{rst_ddr_c}};
            port_q <= {PORTS{rst_port_c}};
            ifr_q  <= '0;
            ier_q  <= '0;
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
            arm_q  <= 2'd0;
        end else begin
            ddr_q  <= ddr_d;
            port_q <= port_d;
            ifr_q  <= ifr_d;
            ier_q  <= ier_d;
            s1_q   <= pio_in_i;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            if (arm_q != 2'd3) arm_q <= arm_q + 2'd1;
        end
    end

endmodule

// File: doc/as65_pio.md
AS65_PIO -- requirements
Module: as65_pio

Interface
REQ-001 SHALL provide parameter WIDTH, default 6, bits per port (legal 1..8).
REQ-002 SHALL provide parameter PORTS, default 1, number of ports (legal 1..4).
REQ-003 SHALL provide parameter BASE, default 16'h0000, first register address; port p occupies BASE+4p .. BASE+4p+3.
REQ-004 SHALL provide parameters DDR_RST and PORT_RST, defaults 8'h00 and 8'h00, normal reset values.
REQ-005 SHALL provide parameters ALT_DDR_RST and ALT_PORT_RST, defaults 8'h2F and 8'h27, preset reset values.
REQ-006 SHALL provide parameter EDGE, default 0; 0 flags falling input edges, 1 flags rising input edges.
REQ-007 SHALL have one clock; reset is synchronous and active-high: clk_i  input  1  sole clock, all state changes on its rising edge.
REQ-008 rst_i  input  1  synchronous active-high reset.
REQ-009 preset_i  input  1  sampled only while rst_i=1; selects ALT_* reset values.
REQ-010 addr_i  input  16  CPU address.
REQ-011 wdata_i  input  8  CPU write data.
REQ-012 we_i  input  1  write strobe, one write per cycle high.
REQ-013 rdata_o  output  8  combinational read data.
REQ-014 hit_o  output  1  combinational, 1 when addr_i falls in BASE..BASE+4*PORTS-1.
REQ-015 pio_in_i  input  PORTS*WIDTH  asynchronous pad inputs; port p uses bits [p*WIDTH +: WIDTH].
REQ-016 pio_out_o  output  PORTS*WIDTH  PORT register contents.
REQ-017 pio_oe_o  output  PORTS*WIDTH  DDR register contents; 1 = output.
REQ-018 irq_n_o  output  1  active-low interrupt request.

Function
REQ-019 Per port, offsets: 0 DDR, 1 PORT, 2 IFR (interrupt flags), 3 IER (interrupt enable); all WIDTH bits wide.
REQ-020 Writes with we_i=1 and hit_o=1 SHALL update the addressed register on the same clock edge; wdata_i bits at and above WIDTH ignored.
REQ-021 IFR writes SHALL be write-1-to-clear per bit; writing 0 leaves the bit unchanged.
REQ-022 Each pad bit SHALL pass through two synchronizer flops (s1, s2) then a history flop s3.
REQ-023 An edge on bit i SHALL be detected when s2!=s3 in the direction selected by EDGE, while DDR[i]=0 and the block is armed.
REQ-024 A detected edge SHALL set IFR[i]; pad change captured into s1 at edge k sets IFR at edge k+2.
REQ-025 Simultaneous edge-set and W1C clear of the same IFR bit: set SHALL win.
REQ-026 Bits with DDR[i]=1 SHALL never set IFR[i]; IFR bits already set persist when DDR changes.
REQ-027 irq_n_o SHALL be the combinational NOR of (IFR & IER) over all bits of all ports.
REQ-028 PORT read SHALL return (DDR & PORT) | (~DDR & s2), zero-extended to 8 bits; DDR, IFR and IER read their register values zero-extended.
REQ-029 rdata_o SHALL be 8'h00 when hit_o=0.
REQ-030 An arm counter SHALL count 0..3 after reset and saturate; edge detection SHALL be enabled only when it reads 3, suppressing edges caused by synchronizer reset.
REQ-031 BASE+4*PORTS exceeding 16'hFFFF SHALL not wrap; addresses past 16'hFFFF are never mapped.

Reset
REQ-032 While rst_i=1: DDR/PORT of every port load ALT_DDR_RST/ALT_PORT_RST (preset_i=1) or DDR_RST/PORT_RST (preset_i=0), truncated to WIDTH.
REQ-033 While rst_i=1: IFR=0, IER=0, s1=s2=s3=0, arm counter=0, writes ignored; irq_n_o=1.
REQ-034 Reset asserted mid-operation SHALL discard pending edges and flags on that same clock edge.

Verification
REQ-035 Reset with preset_i=1, WIDTH=6 -> pio_oe_o=6'h2F, pio_out_o=6'h27, irq_n_o=1; preset_i=0 -> both 0.
REQ-036 Write DDR=8'h0F, PORT=8'hA5 at BASE; pads=6'h30 -> read PORT returns 8'h35, pio_out_o=6'h25.
REQ-037 EDGE=0, IER[2]=1, pad bit2 1->0 captured at edge k -> IFR=6'h04 at k+2, irq_n_o low; write IFR 8'h04 -> irq_n_o high next cycle.
REQ-038 Edge-set and W1C of same bit in same cycle -> bit remains 1.
REQ-039 PORTS=2, pads held high through reset release with EDGE=1 -> no flags set; address BASE+8 -> hit_o=0, rdata_o=0.
